// File: rtl/uart_tx_serializer.sv
// Asynchronous-frame transmitter: accepts a parallel word over valid/ready and
// shifts out start, LSB-first data, optional parity and stop bits on baud_tick.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                 state_reg, state_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   par_reg, par_next;
  logic                   tx_reg, tx_next;
  logic                   done_reg, done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_valid) begin
          // Parity is computed from the whole word at acceptance, before shifting.
          state_next = ARMED;
          shift_next = tx_data;
          cnt_next   = '0;
          par_next   = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
        end
      end
      ARMED: begin
        if (baud_tick) begin
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          cnt_next   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt_reg == LAST_DATA) begin
            cnt_next = '0;
            if (PARITY != 0) begin
              state_next = PAR;
              tx_next    = par_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            cnt_next   = cnt_reg + CW'(1);
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
      end
      PAR: begin
        if (baud_tick) begin
          state_next = STOP;
          tx_next    = 1'b1;
          cnt_next   = '0;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud_tick) begin
          if (cnt_reg == LAST_STOP) begin
            state_next = IDLE;
            done_next  = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign tx       = tx_reg;
  assign tx_done  = done_reg;

endmodule
